// File: rtl/sequence_detector_1100.sv
// Non-overlapping Mealy detector for the serial pattern 1-1-0-0 on x.
// Define SEQ_DET_CNT_EN to add the saturating det_cnt detection counter output.
module sequence_detector_1100 #(
   parameter int CNT_WIDTH = 8
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 x,
   output logic                 z
`ifdef SEQ_DET_CNT_EN
   ,
   output logic [CNT_WIDTH-1:0] det_cnt
`endif
);

   typedef enum logic [1:0] {
      S0 = 2'b00,
      S1 = 2'b01,
      S2 = 2'b10,
      S3 = 2'b11
   } state_t;

   state_t state_q;
   state_t state_d;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q <= S0;
      end else begin
         state_q <= state_d;
      end
   end

   // A completed pattern always returns to S0 so no bits are shared between detections.
   always_comb begin
      state_d = S0;
      z       = 1'b0;
      case (state_q)
         S0: state_d = x ? S1 : S0;
         S1: state_d = x ? S2 : S0;
         S2: state_d = x ? S2 : S3;
         S3: begin
            state_d = x ? S1 : S0;
            z       = ~x;
         end
         default: begin
            state_d = S0;
            z       = 1'b0;
         end
      endcase
   end

`ifdef SEQ_DET_CNT_EN
   logic [CNT_WIDTH-1:0] cnt_q;
   logic [CNT_WIDTH-1:0] cnt_d;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   // Saturate at all-ones instead of wrapping.
   always_comb begin
      cnt_d = cnt_q;
      if (z && (cnt_q != {CNT_WIDTH{1'b1}})) begin
         cnt_d = cnt_q + 1'b1;
      end
   end

   assign det_cnt = cnt_q;
`else
   logic unused_cnt_width;
   assign unused_cnt_width = CNT_WIDTH[0];
`endif

endmodule

// File: tb/tb_sequence_detector_1100.sv
// Directed self-checking bench for sequence_detector_1100.
// Counter checks are compiled in only when SEQ_DET_CNT_EN is defined.
module tb_sequence_detector_1100;

   localparam int CNT_WIDTH = 2;

   logic clk;
   logic rst;
   logic x;
   logic z;
`ifdef SEQ_DET_CNT_EN
   logic [CNT_WIDTH-1:0] det_cnt;
   logic [CNT_WIDTH-1:0] exp_cnt;
`endif

   int checks;
   int errors;

   sequence_detector_1100 #(
      .CNT_WIDTH(CNT_WIDTH)
   ) dut (
      .clk(clk),
      .rst(rst),
      .x  (x),
      .z  (z)
`ifdef SEQ_DET_CNT_EN
      ,
      .det_cnt(det_cnt)
`endif
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
      checks++;
      assert (observed === expected) else begin
         errors++;
         $error("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
      end
   endtask

   // Drive one bit at the falling edge, then check z mid-cycle (and det_cnt from prior edges).
   task automatic applyStimulus(input logic bit_in, input logic exp_z, input string tag);
      @(negedge clk);
      x = bit_in;
      #1;
      checkOutput({tag, " z"}, {31'd0, z}, {31'd0, exp_z});
`ifdef SEQ_DET_CNT_EN
      checkOutput({tag, " det_cnt"}, {{(32-CNT_WIDTH){1'b0}}, det_cnt}, {{(32-CNT_WIDTH){1'b0}}, exp_cnt});
      if (exp_z && (exp_cnt != {CNT_WIDTH{1'b1}})) exp_cnt = exp_cnt + 1'b1;
`endif
   endtask

   // Bits and expected z are given MSB-first: bit n-1 is applied first.
   task automatic applySequence(input string tag, input int n, input logic [31:0] bits, input logic [31:0] exp_z);
      for (int i = n - 1; i >= 0; i--) begin
         applyStimulus(bits[i], exp_z[i], $sformatf("%s bit%0d", tag, n - i));
      end
   endtask

   initial begin
      checks = 0;
      errors = 0;
      rst    = 1'b0;
      x      = 1'b0;
`ifdef SEQ_DET_CNT_EN
      exp_cnt = '0;
`endif

      // Reset held: z stays low while x toggles.
      applySequence("reset_hold", 6, 32'b110100, 32'b000000);
      @(negedge clk);
      rst = 1'b1;

      applySequence("basic_1100", 4, 32'b1100, 32'b0001);

      applySequence("stream", 17, 32'b11001101100110010, 32'b00010000001000100);

      applySequence("lead_ones", 6, 32'b111100, 32'b000001);

      applySequence("no_overlap_a", 7, 32'b1100100, 32'b0001000);
      applySequence("no_overlap_b", 7, 32'b1101100, 32'b0000001);

      // Mid-pattern reset: reach S3 with x=0 (z high), then assert reset between edges.
      applySequence("mid_reset_pre", 3, 32'b110, 32'b000);
      @(posedge clk);
      #1;
      checkOutput("mid_reset in_S3 z", {31'd0, z}, 32'd1);
      #1;
      rst = 1'b0;
      #1;
      checkOutput("mid_reset async z", {31'd0, z}, 32'd0);
`ifdef SEQ_DET_CNT_EN
      exp_cnt = '0;
      checkOutput("mid_reset async det_cnt", {{(32-CNT_WIDTH){1'b0}}, det_cnt}, 32'd0);
`endif
      @(negedge clk);
      rst = 1'b1;
      applyStimulus(1'b0, 1'b0, "mid_reset final0");
      applySequence("mid_reset fresh", 4, 32'b1100, 32'b0001);

`ifdef SEQ_DET_CNT_EN
      // Counter saturation: five back-to-back patterns from a cleared counter.
      @(negedge clk);
      rst = 1'b0;
      exp_cnt = '0;
      #1;
      checkOutput("sat_prep det_cnt", {{(32-CNT_WIDTH){1'b0}}, det_cnt}, 32'd0);
      @(negedge clk);
      rst = 1'b1;
      for (int p = 0; p < 5; p++) begin
         applySequence($sformatf("sat p%0d", p), 4, 32'b1100, 32'b0001);
      end
      applyStimulus(1'b0, 1'b0, "sat final");
      checkOutput("sat end det_cnt", {{(32-CNT_WIDTH){1'b0}}, det_cnt}, 32'd3);
      #1;
      rst = 1'b0;
      #1;
      checkOutput("sat reset det_cnt", {{(32-CNT_WIDTH){1'b0}}, det_cnt}, 32'd0);
      rst = 1'b1;
`endif

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
